// File: rtl/x2_bist_pkg.sv
// x2_bist_pkg: shared state codes, LFSR/MISR taps and response bit order
// for the x2 decode self-test wrapper.
package x2_bist_pkg;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_DONE  = 2'd3;
    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;
    localparam int MISR_TAP_HI = 6;
    localparam int MISR_TAP_LO = 5;
    // pk lands on this response bit, pl..pq follow toward bit 0
    localparam int RESP_PK_BIT = 6;

    function automatic logic [9:0] lfsr_next(input logic [9:0] s);
        return {s[8:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction
endpackage

// File: rtl/x2_bist_misr.sv
// x2_bist_misr: 7-bit multiple-input signature register with load and enable,
// reusable for any 7-output decode benchmark.
module x2_bist_misr
    import x2_bist_pkg::*;
#(
    parameter logic [6:0] SEED = 7'h00
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [6:0] data_i,
    output logic [6:0] sig_o
);
    logic [6:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_i)
            sig_d = SEED;
        else if (en_i)
            sig_d = {sig_q[5:0], sig_q[MISR_TAP_HI] ^ sig_q[MISR_TAP_LO]} ^ data_i;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i)
            sig_q <= SEED;
        else
            sig_q <= sig_d;
    end

    assign sig_o = sig_q;
endmodule

// File: rtl/x2_bist_driver.sv
// x2_bist_driver: drives LFSR vectors onto an x2 decode block and compacts
// its delayed responses into a MISR signature.
module x2_bist_driver
    import x2_bist_pkg::*;
#(
    parameter int         NUM_PATTERNS = 1023,
    parameter logic [9:0] LFSR_SEED    = 10'h001,
    parameter logic [6:0] MISR_SEED    = 7'h00,
    parameter int         RESP_LATENCY = 1
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [9:0] seed_in_i,
    output logic       pa_o,
    output logic       pb_o,
    output logic       pc_o,
    output logic       pd_o,
    output logic       pe_o,
    output logic       pf_o,
    output logic       pg_o,
    output logic       ph_o,
    output logic       pi_o,
    output logic       pj_o,
    input  logic       pk_i,
    input  logic       pl_i,
    input  logic       pm_i,
    input  logic       pn_i,
    input  logic       po_i,
    input  logic       pp_i,
    input  logic       pq_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [6:0] signature_o,
    output logic [9:0] pattern_count_o
);
    localparam logic [9:0] NUM = 10'(NUM_PATTERNS);

    state_t                  state_q, state_d;
    logic [9:0]              lfsr_q, lfsr_d, cnt_q, cnt_d;
    logic [RESP_LATENCY-1:0] vld_q, vld_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [6:0]              resp;
    logic [9:0]              seed;
    logic                    go, cnt_end, issue, samp, last;

    assign resp[RESP_PK_BIT -: 7] = {pk_i, pl_i, pm_i, pn_i, po_i, pp_i, pq_i};
    assign seed    = (seed_in_i == 10'd0) ? LFSR_SEED : seed_in_i;
    assign go      = !abort_i && start_i && (state_q == S_IDLE || state_q == S_DONE);
    assign cnt_end = (state_q == S_RUN) && (cnt_q + 10'd1 == NUM);
    assign issue   = go || (!abort_i && state_q == S_RUN && !cnt_end);
    assign samp    = !abort_i && vld_q[RESP_LATENCY-1];
    // one valid bit per vector in flight; the run ends when the line empties
    assign vld_d   = abort_i ? '0 : RESP_LATENCY'({vld_q, issue});
    assign last    = samp && (vld_d == '0);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (abort_i) begin
            state_d = S_IDLE;
            lfsr_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else if (go) begin
            state_d = S_RUN;
            lfsr_d  = seed;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else begin
            if (state_q == S_RUN) begin
                cnt_d   = (cnt_q == NUM) ? cnt_q : cnt_q + 10'd1;
                lfsr_d  = cnt_end ? lfsr_q : lfsr_next(lfsr_q);
                state_d = cnt_end ? S_DRAIN : S_RUN;
            end
            if (last) begin
                state_d = S_DONE;
                lfsr_d  = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    x2_bist_misr #(.SEED(MISR_SEED)) u_misr (
        .clock_i  (clock_i),
        .reset_n_i(reset_n_i),
        .load_i   (go),
        .en_i     (samp),
        .data_i   (resp),
        .sig_o    (signature_o)
    );

    assign {pa_o, pb_o, pc_o, pd_o, pe_o, pf_o, pg_o, ph_o, pi_o, pj_o} = lfsr_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pattern_count_o = cnt_q;
endmodule

// File: tb/tb_x2_bist_driver.sv
// tb_x2_bist_driver: directed and randomized checks of x2_bist_driver across
// four parameterizations against a behavioural vector/signature model.
module tb_x2_bist_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst_n, f_start, f_abort, a_start, b_start, c_start;
    logic [9:0] f_seed;
    logic [6:0] a_r, b_r, c_r;
    wire  [9:0] f_v, a_v, b_v, c_v, f_cnt, a_cnt, b_cnt, c_cnt;
    wire  [6:0] f_r, f_sig, a_sig, b_sig, c_sig;
    wire        f_busy, f_done, a_busy, a_done, b_busy, b_done, c_busy, c_done;

    // stand-in for the combinational x2 decode block
    function automatic logic [6:0] x2_dec(input logic [9:0] v);
        return {^v[9:5], v[0] & v[1], v[2] | v[3], v[4] ^ v[7], &v[8:6],
                v[9] ^ v[0] ^ v[5], (|v[3:1]) & v[4]};
    endfunction

    // multiply by x modulo x^10+x^7+1, read as a shift register
    function automatic logic [9:0] lfsr_ref(input logic [9:0] s);
        return ((s << 1) & 10'h3FF) | 10'(^(s & 10'h240));
    endfunction

    function automatic logic [6:0] misr_ref(input logic [6:0] m, input logic [6:0] r);
        return ((m << 1) & 7'h7F) ^ 7'((m >> 6) ^ ((m >> 5) & 7'h1)) ^ r;
    endfunction

    assign f_r = x2_dec(f_v);

    x2_bist_driver u_f (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(f_start), .abort_i(f_abort), .seed_in_i(f_seed),
        .pa_o(f_v[9]), .pb_o(f_v[8]), .pc_o(f_v[7]), .pd_o(f_v[6]), .pe_o(f_v[5]),
        .pf_o(f_v[4]), .pg_o(f_v[3]), .ph_o(f_v[2]), .pi_o(f_v[1]), .pj_o(f_v[0]),
        .pk_i(f_r[6]), .pl_i(f_r[5]), .pm_i(f_r[4]), .pn_i(f_r[3]), .po_i(f_r[2]), .pp_i(f_r[1]), .pq_i(f_r[0]),
        .busy_o(f_busy), .done_o(f_done), .signature_o(f_sig), .pattern_count_o(f_cnt));

    x2_bist_driver #(.NUM_PATTERNS(4), .LFSR_SEED(10'h2A5), .RESP_LATENCY(1)) u_a (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(a_start), .abort_i(1'b0), .seed_in_i(10'd0),
        .pa_o(a_v[9]), .pb_o(a_v[8]), .pc_o(a_v[7]), .pd_o(a_v[6]), .pe_o(a_v[5]),
        .pf_o(a_v[4]), .pg_o(a_v[3]), .ph_o(a_v[2]), .pi_o(a_v[1]), .pj_o(a_v[0]),
        .pk_i(a_r[6]), .pl_i(a_r[5]), .pm_i(a_r[4]), .pn_i(a_r[3]), .po_i(a_r[2]), .pp_i(a_r[1]), .pq_i(a_r[0]),
        .busy_o(a_busy), .done_o(a_done), .signature_o(a_sig), .pattern_count_o(a_cnt));

    x2_bist_driver #(.NUM_PATTERNS(2), .RESP_LATENCY(3)) u_b (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(b_start), .abort_i(1'b0), .seed_in_i(10'd0),
        .pa_o(b_v[9]), .pb_o(b_v[8]), .pc_o(b_v[7]), .pd_o(b_v[6]), .pe_o(b_v[5]),
        .pf_o(b_v[4]), .pg_o(b_v[3]), .ph_o(b_v[2]), .pi_o(b_v[1]), .pj_o(b_v[0]),
        .pk_i(b_r[6]), .pl_i(b_r[5]), .pm_i(b_r[4]), .pn_i(b_r[3]), .po_i(b_r[2]), .pp_i(b_r[1]), .pq_i(b_r[0]),
        .busy_o(b_busy), .done_o(b_done), .signature_o(b_sig), .pattern_count_o(b_cnt));

    x2_bist_driver #(.NUM_PATTERNS(1), .RESP_LATENCY(2)) u_c (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(c_start), .abort_i(1'b0), .seed_in_i(10'd0),
        .pa_o(c_v[9]), .pb_o(c_v[8]), .pc_o(c_v[7]), .pd_o(c_v[6]), .pe_o(c_v[5]),
        .pf_o(c_v[4]), .pg_o(c_v[3]), .ph_o(c_v[2]), .pi_o(c_v[1]), .pj_o(c_v[0]),
        .pk_i(c_r[6]), .pl_i(c_r[5]), .pm_i(c_r[4]), .pn_i(c_r[3]), .po_i(c_r[2]), .pp_i(c_r[1]), .pq_i(c_r[0]),
        .busy_o(c_busy), .done_o(c_done), .signature_o(c_sig), .pattern_count_o(c_cnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // full 1023-vector run on u_f against the model; seed 0 means LFSR_SEED
    task automatic run_full(input logic [9:0] seed);
        logic [9:0] v;
        logic [6:0] m;
        bit         seen [1024];
        logic [9:0] seq_tab [8];
        seq_tab = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h081};
        foreach (seen[i]) seen[i] = 1'b0;
        v = (seed == 10'd0) ? 10'h001 : seed;
        m = 7'h00;
        f_seed = seed;
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        chk("full_v0", f_v, v);
        chk("full_busy0", f_busy, 1);
        chk("full_cnt0", f_cnt, 0);
        chk("full_sig0", f_sig, 0);
        seen[f_v] = 1'b1;
        for (int k = 1; k < 1023; k++) begin
            m = misr_ref(m, x2_dec(v));
            v = lfsr_ref(v);
            tick();
            chk("full_vec", f_v, v);
            chk("full_cnt", f_cnt, k);
            chk("full_sig", f_sig, m);
            chk("full_norepeat", seen[f_v], 0);
            seen[f_v] = 1'b1;
            if (seed == 10'd0 && k < 8) chk("seq", f_v, seq_tab[k]);
        end
        m = misr_ref(m, x2_dec(v));
        tick();
        chk("full_done", f_done, 1);
        chk("full_busy_end", f_busy, 0);
        chk("full_cnt_end", f_cnt, 1023);
        chk("full_sig_end", f_sig, m);
        chk("full_vec_end", f_v, 0);
    endtask

    initial begin
        logic [6:0] m, frozen;
        logic [9:0] s;
        rst_n = 1'b0;
        {f_start, f_abort, a_start, b_start, c_start} = '0;
        f_seed = 10'd0;
        a_r = 7'h01;
        b_r = 7'h00;
        c_r = 7'($urandom_range(1, 127));
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_vec", f_v, 0);
        chk("rst_busy", f_busy, 0);
        chk("rst_done", f_done, 0);
        chk("rst_cnt", f_cnt, 0);
        chk("rst_sig", f_sig, 0);
        chk("rst_a_sig", a_sig, 0);

        // NUM=4, L=1, responses 7'h01: signature walks 01,03,07,0F
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("a_v0_default_seed", a_v, 10'h2A5);
        chk("a_busy_e0", a_busy, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("a_sig_walk", a_sig, (32'h1 << k) - 1);
            chk("a_busy", a_busy, k < 4);
            chk("a_done", a_done, k == 4);
        end
        chk("a_cnt_end", a_cnt, 4);
        chk("a_vec_end", a_v, 0);
        tick();
        chk("a_hold_sig", a_sig, 7'h0F);
        chk("a_hold_done", a_done, 1);

        // second u_a run with a random response pattern
        a_r = 7'($urandom);
        m = 7'h00;
        for (int k = 0; k < 4; k++) m = misr_ref(m, a_r);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("a2_done_cleared", a_done, 0);
        chk("a2_sig_load", a_sig, 0);
        repeat (4) tick();
        chk("a2_done", a_done, 1);
        chk("a2_sig", a_sig, m);

        // NUM=2, L=3; start held while busy must be ignored
        b_start = 1'b1;
        tick();
        chk("b_v0", b_v, 10'h001);
        tick();
        b_start = 1'b0;
        chk("b_start_ignored_vec", b_v, 10'h002);
        chk("b_start_ignored_cnt", b_cnt, 1);
        tick();
        chk("b_drain_hold_vec", b_v, 10'h002);
        chk("b_drain_cnt", b_cnt, 2);
        chk("b_drain_busy", b_busy, 1);
        tick();
        chk("b_e3_busy", b_busy, 1);
        chk("b_e3_done", b_done, 0);
        tick();
        chk("b_done", b_done, 1);
        chk("b_busy_end", b_busy, 0);
        chk("b_sig_zero", b_sig, 0);
        chk("b_vec_end", b_v, 0);

        // NUM=1 boundary: one RUN cycle then drain
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        chk("c_busy_e0", c_busy, 1);
        tick();
        chk("c_cnt", c_cnt, 1);
        chk("c_vec_hold", c_v, 10'h001);
        chk("c_done_e1", c_done, 0);
        tick();
        chk("c_done", c_done, 1);
        chk("c_busy", c_busy, 0);
        chk("c_sig", c_sig, misr_ref(7'h00, c_r));

        // reset in DRAIN on u_b with a nonzero response
        b_r = 7'($urandom_range(1, 127));
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        repeat (3) tick();
        chk("b2_sig_pre", b_sig, misr_ref(7'h00, b_r));
        chk("b2_busy_pre", b_busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("b2_rst_busy", b_busy, 0);
        chk("b2_rst_done", b_done, 0);
        chk("b2_rst_sig", b_sig, 0);
        chk("b2_rst_cnt", b_cnt, 0);
        chk("b2_rst_vec", b_v, 0);
        tick();
        chk("b2_idle_sig", b_sig, 0);
        chk("b2_idle_done", b_done, 0);

        // full-length run from the default seed
        run_full(10'd0);

        // abort together with start two edges into a run
        s = 10'($urandom_range(1, 1023));
        f_seed = s;
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        tick();
        frozen = misr_ref(7'h00, x2_dec(s));
        f_abort = 1'b1;
        f_start = 1'b1;
        tick();
        f_abort = 1'b0;
        f_start = 1'b0;
        chk("abort_busy", f_busy, 0);
        chk("abort_done", f_done, 0);
        chk("abort_vec", f_v, 0);
        chk("abort_sig_frozen", f_sig, frozen);
        chk("abort_cnt_frozen", f_cnt, 1);
        tick();
        chk("abort_idle_sig", f_sig, frozen);
        chk("abort_idle_busy", f_busy, 0);

        // fresh run from a random seed after the abort
        run_full(10'($urandom_range(1, 1023)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
